// File: rtl/shiftadd_mult_seq.sv
// Sequential shift-add multiplier feeding the folding reducer: OP_LENGTH x OP_LENGTH product,
// modulus bit length and class on a valid/ready output. SHIFTADD_RADIX4_EN selects two bits per cycle.
module shiftadd_mult_seq #(
  parameter int unsigned OP_LENGTH   = 32,
  parameter int unsigned DATA_LENGTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [OP_LENGTH-1:0]   a_i,
  input  logic [OP_LENGTH-1:0]   b_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_LENGTH-1:0] x_o,
  output logic [DATA_LENGTH-1:0] m_o,
  output logic [DATA_LENGTH-1:0] m_bl_o,
  output logic [1:0]             kind_o
);

`ifdef SHIFTADD_RADIX4_EN
  localparam int unsigned SHIFT = 2;
`else
  localparam int unsigned SHIFT = 1;
`endif
  localparam int unsigned STEPS = OP_LENGTH / SHIFT;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  localparam logic [1:0] KIND_GENERIC  = 2'd0;
  localparam logic [1:0] KIND_MERSENNE = 2'd1;
  localparam logic [1:0] KIND_FERMAT   = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_ready;
  logic                   r_valid;
  logic                   w_ready_nxt;
  logic                   w_valid_nxt;
  logic                   w_accept;
  logic                   w_last;

  logic [DATA_LENGTH-1:0] r_acc;
  logic [DATA_LENGTH-1:0] r_a_sh;
  logic [OP_LENGTH-1:0]   r_b_sh;
  logic [CNT_W-1:0]       r_cnt;
  logic [DATA_LENGTH-1:0] r_x;
  logic [DATA_LENGTH-1:0] r_m;
  logic [DATA_LENGTH-1:0] r_m_bl;
  logic [1:0]             r_kind;

  logic [DATA_LENGTH-1:0] w_acc_nxt;
  logic [DATA_LENGTH-1:0] w_bl;
  logic [DATA_LENGTH-1:0] w_m_dec;
  logic                   w_is_mers;
  logic                   w_is_ferm;
  logic [1:0]             w_kind;

  assign w_accept = (r_state == IDLE) && valid_i;
  assign w_last   = (r_cnt == LAST_CNT);

  // State register; ready/valid are registered copies of the next-state decode
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = 1'b0;
    w_valid_nxt = 1'b0;
    case (r_state)
      IDLE:    if (valid_i) w_state_nxt = MUL;
      MUL:     if (w_last)  w_state_nxt = DONE;
      DONE:    if (ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == IDLE);
    w_valid_nxt = (w_state_nxt == DONE);
  end

  // One shift-add step; the sum never exceeds DATA_LENGTH bits for 2*OP_LENGTH widths
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_b_sh[0]) w_acc_nxt = w_acc_nxt + r_a_sh;
`ifdef SHIFTADD_RADIX4_EN
    if (r_b_sh[1]) w_acc_nxt = w_acc_nxt + (r_a_sh << 1);
`endif
  end

  // Modulus bit length and class, evaluated on the incoming modulus at accept
  always_comb begin
    w_bl = '0;
    for (int unsigned i = 0; i < DATA_LENGTH; i++) begin
      if (m_i[i]) w_bl = DATA_LENGTH'(i + 1);
    end
    w_m_dec   = m_i - DATA_LENGTH'(1);
    w_is_mers = (m_i != '0) && ((m_i & (m_i + DATA_LENGTH'(1))) == '0);
    w_is_ferm = (m_i >= DATA_LENGTH'(3)) && ((w_m_dec & (w_m_dec - DATA_LENGTH'(1))) == '0);
    if (w_is_mers)      w_kind = KIND_MERSENNE;
    else if (w_is_ferm) w_kind = KIND_FERMAT;
    else                w_kind = KIND_GENERIC;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc  <= '0;
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_cnt  <= '0;
      r_x    <= '0;
      r_m    <= '0;
      r_m_bl <= '0;
      r_kind <= 2'd0;
    end else if (w_accept) begin
      r_acc  <= '0;
      r_a_sh <= DATA_LENGTH'(a_i);
      r_b_sh <= b_i;
      r_cnt  <= '0;
      r_m    <= m_i;
      r_m_bl <= w_bl;
      r_kind <= w_kind;
    end else if (r_state == MUL) begin
      r_acc  <= w_acc_nxt;
      r_a_sh <= r_a_sh << SHIFT;
      r_b_sh <= r_b_sh >> SHIFT;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) r_x <= w_acc_nxt;
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign x_o     = r_x;
  assign m_o     = r_m;
  assign m_bl_o  = r_m_bl;
  assign kind_o  = r_kind;

endmodule
